pc_sequencer: RTL

Sequencing controller for the 6502 program counter. It owns the PCL and PCH registers and runs the PC update for each operation:
- increment, with carry from PCL into PCH
- two-byte absolute jump
- signed relative branch, with an extra fix-up cycle on a page cross
- direct 16-bit load
The CPU control unit issues commands over a valid/ready handshake; PCL/PCH drive the address mux.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_low_adder.sv | 27 ++
 rtl/pc_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the 6502 program-counter sequencer.
package pc_pkg;

   typedef enum logic [2:0] {
      CmdNop    = 3'd0,
      CmdInc    = 3'd1,
      CmdJmp    = 3'd2,
      CmdBranch = 3'd3,
      CmdLoad   = 3'd4
   } pc_cmd_t;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StJmpHi = 2'd1,
      StBrFix = 2'd2
   } pc_state_t;

   typedef enum logic {
      AddInc    = 1'b0,
      AddSigned = 1'b1
   } add_mode_t;

   localparam logic [15:0] PC_RESET_DEFAULT = 16'hFFFC;

endpackage

// File: rtl/pc_low_adder.sv
// PCL adder: either +1 or a signed 8-bit branch offset, with page-cross analysis.
module pc_low_adder
   import pc_pkg::*;
(
   input  logic [7:0] i_pcl,
   input  logic [7:0] i_operand,
   input  add_mode_t  i_mode,
   output logic [7:0] o_pcl,
   output logic       o_carry,
   output logic       o_page_cross,
   output logic       o_dir_neg
);

   logic [8:0] w_sum9;
   logic [7:0] w_addend;

   always_comb begin
      w_addend  = (i_mode == AddInc) ? 8'h01 : i_operand;
      w_sum9    = {1'b0, i_pcl} + {1'b0, w_addend};
      o_pcl     = w_sum9[7:0];
      o_carry   = w_sum9[8];
      o_dir_neg = (i_mode == AddSigned) && i_operand[7];
      // A negative offset borrows from PCH exactly when the 8-bit add does not carry.
      o_page_cross = o_dir_neg ? ~w_sum9[8] : w_sum9[8];
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns PCL/PCH and runs INC, JMP, BRANCH and LOAD updates.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter logic [15:0] RESET_PC = PC_RESET_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_N,
   input  logic [2:0]  cmd_IN,
   input  logic        cmdValid_IN,
   output logic        cmdReady_OUT,
   input  logic [7:0]  data_IN,
   input  logic        dataValid_IN,
   input  logic [15:0] load_IN,
   output logic [7:0]  pcLow_OUT,
   output logic [7:0]  pcHigh_OUT,
   output logic        busy_OUT,
   output logic        done_OUT,
   output logic        pageCross_OUT
);

   pc_state_t r_state;
   pc_state_t w_state_next;

   logic [7:0] r_pcl;
   logic [7:0] r_pch;
   logic [7:0] r_tmp_low;
   logic       r_dir_neg;
   logic       r_done;
   logic       r_page_cross;

   logic [7:0] w_pcl_d;
   logic [7:0] w_pch_d;
   logic [7:0] w_tmp_low_d;
   logic       w_dir_neg_d;
   logic       w_done_d;
   logic       w_page_cross_d;

   pc_cmd_t    w_cmd;
   logic       w_accept;
   add_mode_t  w_add_mode;
   logic [7:0] w_add_pcl;
   logic       w_add_carry;
   logic       w_add_page_cross;
   logic       w_add_dir_neg;

   assign w_cmd      = pc_cmd_t'(cmd_IN);
   assign w_accept   = cmdValid_IN && (r_state == StIdle);
   assign w_add_mode = (w_cmd == CmdInc) ? AddInc : AddSigned;

   pc_low_adder u_low_adder (
      .i_pcl        (r_pcl),
      .i_operand    (data_IN),
      .i_mode       (w_add_mode),
      .o_pcl        (w_add_pcl),
      .o_carry      (w_add_carry),
      .o_page_cross (w_add_page_cross),
      .o_dir_neg    (w_add_dir_neg)
   );

   // State register
   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               case (w_cmd)
                  CmdJmp:    w_state_next = StJmpHi;
                  CmdBranch: w_state_next = w_add_page_cross ? StBrFix : StIdle;
                  default:   w_state_next = StIdle;
               endcase
            end
         end
         StJmpHi: begin
            if (dataValid_IN) begin
               w_state_next = StIdle;
            end
         end
         StBrFix: w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Datapath next-state; done/pageCross are registered so they line up with the new PC.
   always_comb begin
      w_pcl_d        = r_pcl;
      w_pch_d        = r_pch;
      w_tmp_low_d    = r_tmp_low;
      w_dir_neg_d    = r_dir_neg;
      w_done_d       = 1'b0;
      w_page_cross_d = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               case (w_cmd)
                  CmdInc: begin
                     w_pcl_d  = w_add_pcl;
                     w_pch_d  = r_pch + {7'd0, w_add_carry};
                     w_done_d = 1'b1;
                  end
                  CmdLoad: begin
                     w_pcl_d  = load_IN[7:0];
                     w_pch_d  = load_IN[15:8];
                     w_done_d = 1'b1;
                  end
                  CmdJmp: begin
                     w_tmp_low_d = data_IN;
                  end
                  CmdBranch: begin
                     w_pcl_d     = w_add_pcl;
                     w_dir_neg_d = w_add_dir_neg;
                     if (w_add_page_cross) begin
                        w_page_cross_d = 1'b1;
                     end else begin
                        w_done_d = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         StJmpHi: begin
            if (dataValid_IN) begin
               w_pcl_d  = r_tmp_low;
               w_pch_d  = data_IN;
               w_done_d = 1'b1;
            end
         end
         StBrFix: begin
            w_pch_d  = r_dir_neg ? (r_pch - 8'd1) : (r_pch + 8'd1);
            w_done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         r_pcl        <= RESET_PC[7:0];
         r_pch        <= RESET_PC[15:8];
         r_tmp_low    <= 8'h00;
         r_dir_neg    <= 1'b0;
         r_done       <= 1'b0;
         r_page_cross <= 1'b0;
      end else begin
         r_pcl        <= w_pcl_d;
         r_pch        <= w_pch_d;
         r_tmp_low    <= w_tmp_low_d;
         r_dir_neg    <= w_dir_neg_d;
         r_done       <= w_done_d;
         r_page_cross <= w_page_cross_d;
      end
   end

   // Output logic
   always_comb begin
      cmdReady_OUT  = (r_state == StIdle);
      busy_OUT      = (r_state != StIdle);
      pcLow_OUT     = r_pcl;
      pcHigh_OUT    = r_pch;
      done_OUT      = r_done;
      pageCross_OUT = r_page_cross;
   end

endmodule
